// File: rtl/vid_out_lock_sequencer.sv
// Purpose: brings up the AXIS-to-video bridge and VTG, waits for lock, and recovers with bounded retries.
// Latency: 2-FF sync on bridge status plus one registered decision cycle; outputs change with state.
// Backpressure: none; a level enable plus status inputs. Optional irq/irq_ack ports under `VID_OUT_SEQ_IRQ_EN.
module vid_out_lock_sequencer #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 1048576,
    parameter int TIMER_W      = 21,
    parameter int RETRY_MAX    = 3
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       cfg_enable,
    input  logic       status_clr,
    input  logic       locked_in,
    input  logic       wr_error_in,
    input  logic       empty_in,
`ifdef VID_OUT_SEQ_IRQ_EN
    input  logic       irq_ack,
    output logic       irq,
`endif
    output logic       vidout_rst,
    output logic       vidout_aclken,
    output logic       vtg_en,
    output logic [2:0] state,
    output logic       lock_timeout,
    output logic       underflow,
    output logic       fault,
    output logic [7:0] recovery_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET     = 3'd1,
        S_START     = 3'd2,
        S_WAIT_LOCK = 3'd3,
        S_LOCKED    = 3'd4,
        S_RECOVER   = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    localparam int RW = $clog2(RST_CYCLES) + 1;

    state_t             state_q, state_d;
    logic [RW-1:0]      rst_cnt_q, rst_cnt_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [3:0]         retry_q, retry_d;
    logic               lt_q, lt_d;
    logic               uf_q, uf_d;
    logic [7:0]         rc_q, rc_d;
    logic [2:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic               rst_q, rst_d, aclken_q, aclken_d, vtg_q, vtg_d;
    logic               locked_s, wr_error_s, empty_s;

    assign locked_s   = sync2_q[0];
    assign wr_error_s = sync2_q[1];
    assign empty_s    = sync2_q[2];

    // Next-state, counters, sticky flags and registered output decode.
    always_comb begin
        sync1_d   = {empty_in, wr_error_in, locked_in};
        sync2_d   = sync1_q;
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        timer_d   = timer_q;
        retry_d   = retry_q;
        lt_d      = lt_q;
        uf_d      = uf_q;
        rc_d      = rc_q;

        // Clear first so that any set/increment below overrides it.
        if (status_clr) begin
            lt_d = 1'b0;
            uf_d = 1'b0;
            rc_d = 8'd0;
        end

        if (state_q != S_IDLE && !cfg_enable) begin
            state_d = S_IDLE;
            retry_d = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cfg_enable) begin
                        state_d   = S_RESET;
                        rst_cnt_d = '0;
                    end
                end
                S_RESET: begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                    if (rst_cnt_q == RW'(RST_CYCLES - 1)) state_d = S_START;
                end
                S_START: begin
                    timer_d = '0;
                    state_d = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    timer_d = timer_q + TIMER_W'(1);
                    if (locked_s) begin
                        state_d = S_LOCKED;
                        retry_d = 4'd0;
                    end else if (timer_q == TIMER_W'(LOCK_TIMEOUT - 1)) begin
                        state_d = S_RECOVER;
                        lt_d    = 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (!locked_s || wr_error_s) state_d = S_RECOVER;
                end
                S_RECOVER: begin
                    if (retry_q < 4'(RETRY_MAX)) begin
                        state_d   = S_RESET;
                        rst_cnt_d = '0;
                        retry_d   = retry_q + 4'd1;
                    end else begin
                        state_d = S_FAULT;
                    end
                end
                S_FAULT:  state_d = S_FAULT;
                default:  state_d = S_IDLE;
            endcase
        end

        // Underflow is observed in LOCKED even on the cycle we leave it.
        if (state_q == S_LOCKED && empty_s) uf_d = 1'b1;

        if (state_d == S_RECOVER && state_q != S_RECOVER && rc_q != 8'hFF)
            rc_d = rc_q + 8'd1;

        rst_d    = (state_d == S_IDLE) || (state_d == S_RESET) ||
                   (state_d == S_RECOVER) || (state_d == S_FAULT);
        aclken_d = !rst_d;
        vtg_d    = !rst_d;
    end

    // State, counters, synchronisers and output registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            rst_cnt_q <= '0;
            timer_q   <= '0;
            retry_q   <= 4'd0;
            lt_q      <= 1'b0;
            uf_q      <= 1'b0;
            rc_q      <= 8'd0;
            sync1_q   <= 3'b000;
            sync2_q   <= 3'b000;
            rst_q     <= 1'b1;
            aclken_q  <= 1'b0;
            vtg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            lt_q      <= lt_d;
            uf_q      <= uf_d;
            rc_q      <= rc_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            rst_q     <= rst_d;
            aclken_q  <= aclken_d;
            vtg_q     <= vtg_d;
        end
    end

`ifdef VID_OUT_SEQ_IRQ_EN
    logic entry_q, entry_d, irq_q, irq_d;

    // Interrupt: raised the cycle after RECOVER/FAULT entry or on underflow rising; ack loses to a set.
    always_comb begin
        entry_d = (state_d != state_q) && (state_d == S_RECOVER || state_d == S_FAULT);
        irq_d   = irq_q;
        if (irq_ack) irq_d = 1'b0;
        if (entry_q || (uf_d && !uf_q)) irq_d = 1'b1;
    end

    // Interrupt registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            entry_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            entry_q <= entry_d;
            irq_q   <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    assign state          = state_q;
    assign vidout_rst     = rst_q;
    assign vidout_aclken  = aclken_q;
    assign vtg_en         = vtg_q;
    assign lock_timeout   = lt_q;
    assign underflow      = uf_q;
    assign fault          = (state_q == S_FAULT);
    assign recovery_count = rc_q;

endmodule

// File: doc/vid_out_lock_sequencer.md
Name: vid_out_lock_sequencer

Overview:
Control sequencer for the AXI4-Stream-to-video-output bridge and its video timing generator (VTG). It drives the bridge reset, the bridge clock enable and the VTG enable, then waits for the bridge `locked` indication. On lock loss, write error or lock timeout it recovers automatically with bounded retries. It sits in the `aclk` domain next to the bridge and exposes status to the processor register block.

Parameters:
- RST_CYCLES, 16: cycles the bridge `rst` is held high per reset attempt (min 2).
- LOCK_TIMEOUT, 1048576: `aclk` cycles allowed in WAIT_LOCK before declaring a timeout (min 4).
- TIMER_W, 21: width of the lock timer; must satisfy 2^TIMER_W > LOCK_TIMEOUT.
- RETRY_MAX, 3: recovery attempts allowed before entering FAULT (1..15).

Ports:
- aclk, in, 1: single clock; all logic is synchronous to it.
- aresetn, in, 1: synchronous, active-low reset.
- cfg_enable, in, 1: software enable, level-sensitive.
- status_clr, in, 1: one-cycle pulse that clears the sticky flags and counters.
- locked_in, in, 1: bridge `locked`, from the video clock domain.
- wr_error_in, in, 1: bridge `wr_error`, from the video clock domain.
- empty_in, in, 1: bridge FIFO `empty`, from the video clock domain.
- vidout_rst, out, 1: active-high reset to the bridge.
- vidout_aclken, out, 1: clock enable to the bridge.
- vtg_en, out, 1: VTG generation enable.
- state, out, 3: current state encoding.
- lock_timeout, out, 1: sticky flag; a WAIT_LOCK timeout occurred.
- underflow, out, 1: sticky flag; FIFO empty was seen while LOCKED.
- fault, out, 1: high while in FAULT.
- recovery_count, out, 8: number of entries into RECOVER, saturating at 255.

Behaviour:
- **Input synchronisers:** `locked_in`, `wr_error_in` and `empty_in` each pass through 2-FF synchronisers (reset value 0), giving `locked_s`, `wr_error_s` and `empty_s`. All decisions below use the synchronised values.
- **Reset state:** `aresetn`=0 at a rising edge gives:
  - state=IDLE
  - vidout_rst=1, vidout_aclken=0, vtg_en=0
  - all flags, counters and timers cleared to 0
- **Output registration:** all outputs are registered and decoded from the next state, so they change in the same cycle as `state`.
- **State encoding:** IDLE=0, RESET=1, START=2, WAIT_LOCK=3, LOCKED=4, RECOVER=5, FAULT=6.
- **Output values per state:**
  - IDLE, RESET, RECOVER, FAULT: rst=1, aclken=0, vtg_en=0.
  - START, WAIT_LOCK, LOCKED: rst=0, aclken=1, vtg_en=1.
- **Global priority:** `cfg_enable`=0 in any non-IDLE state moves to IDLE next cycle and clears `retry_cnt`. This overrides every other transition.
- **State transitions:**
  - IDLE: `cfg_enable`=1 → RESET on the next cycle; `rst_cnt` loaded with 0.
  - RESET: `rst_cnt` increments each cycle. When `rst_cnt`==RST_CYCLES-1 → START. Exactly RST_CYCLES cycles are spent in RESET.
  - START: one cycle; clears the lock timer → WAIT_LOCK.
  - WAIT_LOCK: the timer increments each cycle.
    - `locked_s`=1 → LOCKED and `retry_cnt` cleared. This takes priority over timeout in the same cycle.
    - Timer==LOCK_TIMEOUT-1 → RECOVER and `lock_timeout` set.
  - LOCKED: `locked_s`=0 or `wr_error_s`=1 → RECOVER. `empty_s`=1 sets `underflow` and causes no transition.
  - RECOVER: one cycle. `recovery_count` increments (saturating at 255) on entry.
    - `retry_cnt`<RETRY_MAX → RESET and `retry_cnt`++.
    - Otherwise → FAULT.
  - FAULT: held until `cfg_enable`=0 → IDLE.
- **Sticky flag clearing:** `status_clr` clears `lock_timeout`, `underflow` and `recovery_count`.
  - If `status_clr` coincides with a set or increment event, the set/increment wins.
  - `status_clr` does not affect `state` or `retry_cnt`.
- **`wr_error_s` outside LOCKED:** ignored.
- **Reset mid-operation:** `aresetn` low in any state returns to the reset state on the next edge, with no partial sequences completed.

Optional Feature:
- Macro `VID_OUT_SEQ_IRQ_EN`.
- **Defined:** adds an `irq` output (1 bit, reset 0) and an `irq_ack` input (1 bit).
  - `irq` is set the cycle after entry to RECOVER or FAULT, or on a rising edge of `underflow`.
  - `irq` is cleared by `irq_ack`=1; a simultaneous set wins.
- **Undefined:** neither port exists and no interrupt logic is present.
- All other behaviour is identical in both builds.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=64, TIMER_W=7, RETRY_MAX=2.
1. **Clean bring-up:** reset, `cfg_enable`=1 at cycle 0, `locked_in`=1 at cycle 10.
   - state goes 1 at cycle 1, 2 at cycle 5, 3 at cycle 6.
   - vidout_rst falls at cycle 5.
   - LOCKED (state=4) at cycle 13, after the 2-FF sync plus 1 cycle.
2. **Lock timeout with retries:** `locked_in` held at 0.
   - Each WAIT_LOCK period lasts exactly 64 cycles.
   - `recovery_count` reaches 3; state ends at 6 with fault=1 and lock_timeout=1.
3. **Write error while LOCKED:** pulse `wr_error_in` for 1 cycle while LOCKED.
   - RECOVER entered 3 cycles later; recovery_count=1.
   - Re-lock succeeds; `retry_cnt` reset, so 2 further errors do not cause FAULT.
4. **Disable mid-sequence:** `cfg_enable`=0 during RESET and again during WAIT_LOCK.
   - Next state is 0 in both cases; vtg_en=0, vidout_rst=1.
5. **Clear vs set collision:** `status_clr` pulsed in the same cycle as RECOVER entry → recovery_count becomes 1, not 0. `empty_in`=1 while LOCKED → underflow=1.
6. **`aresetn` mid-operation:** `aresetn`=0 for 1 cycle while LOCKED → all outputs at reset values on the next cycle, and the sequence restarts from IDLE.
